instruction_decode: RTL and testbench
=====================================

Name: instruction_decode

Overview:
- Decode stage of the 5-stage MIPS pipeline. Sits directly downstream of the fetch stage.
- Captures the fetched instruction and PC+1 into an internal IF/ID register.
- Reads the 32x32 register file and decodes control.
- Resolves branches and jumps in ID, driving the fetch stage's PC-select and jump target back upstream.
- Registers operands and control into the ID/EX boundary for execute.

Parameters:
- len, 32, datapath/instruction/PC width (PC is a word address, incremented by 1).
- nb_addr, 5, register-file address width (2**nb_addr registers).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_pc_plus1  in  len  PC+1 from fetch.
- in_instruction  in  len  fetched instruction.
- in_stall  in  1  hazard-unit load-use stall.
- in_wb_write  in  1  write-back enable.
- in_wb_addr  in  nb_addr  write-back register.
- in_wb_data  in  len  write-back data.
- out_pc_src  out  1  combinational; 1 = fetch must load out_pc_jump.
- out_pc_jump  out  len  combinational branch/jump target.
- out_reg_a, out_reg_b  out  len  registered rs/rt values.
- out_imm_ext  out  len  registered sign-extended imm[15:0].
- out_rs, out_rt, out_rd  out  nb_addr  registered register fields.
- out_reg_write, out_mem_to_reg, out_mem_read, out_mem_write, out_alu_src, out_reg_dst  out  1 each  registered control.
- out_alu_op  out  2  registered: 00 add, 01 sub, 10 R-type funct.

Behaviour:
- Reset: IF/ID instruction=0, valid=0, pc=0; register file all 0; every ID/EX output 0.
- IF/ID register:
  - Normal: load inputs and set valid=1.
  - in_stall=1: hold contents.
  - out_pc_src=1 (and no stall): load valid=0 (flush of the wrong-path instruction).
- Register file:
  - Write on rising edge when in_wb_write=1 and in_wb_addr!=0.
  - Register 0 always reads 0.
  - Read bypass: same-cycle write to the read address returns in_wb_data, never for address 0.
- Decode, from the IF/ID instruction; opcode = instr[31:26]:
  - 0x00 R-type: reg_write, reg_dst, alu_op=10.
  - 0x08 addi: reg_write, alu_src, alu_op=00.
  - 0x23 lw: reg_write, alu_src, mem_read, mem_to_reg, alu_op=00.
  - 0x2B sw: alu_src, mem_write, alu_op=00.
  - 0x04 beq, 0x05 bne: alu_op=01, no write.
  - 0x02 j: no write.
  - Any other opcode: all control 0.
- Branch/jump, combinational from IF/ID plus register read (with bypass):
  - beq taken when A==B; bne taken when A!=B.
  - Branch target = pc_plus1 + sext(imm) (mod 2^len, wrap-around allowed).
  - j target = {pc_plus1[len-1:26], instr[25:0]}.
  - out_pc_src = valid & !in_stall & (taken branch | j).
  - out_pc_jump = target when out_pc_src=1, else pc_plus1.
- ID/EX register, updated every edge:
  - If valid=0 or in_stall=1: all control outputs 0 (bubble). Data outputs may update but are don't-care.
  - Else: decoded values.
- Latency: instruction on in_instruction before edge k is captured at edge k. Its ID/EX outputs are valid after edge k+1. out_pc_src is valid during cycle k→k+1.
- Simultaneous stall and taken branch: stall wins. pc_src=0; branch re-evaluated next cycle.
- Reset mid-operation: all state cleared in the same edge regardless of stall/wb inputs; register file cleared.

Test Plan:
- Reset with garbage inputs held 3 cycles → all outputs 0, out_pc_src=0; then read r5 via add instr → out_reg_a=0.
- Write r3=0x0000_00AA (wb), same cycle decode add r1,r3,r3 → out_reg_a=out_reg_b=0xAA (bypass), reg_write=1, reg_dst=1, alu_op=10; write to r0 then read r0 → 0.
- beq r3,r3,-2 at pc_plus1=0x10 → out_pc_src=1, out_pc_jump=0x0E; next edge IF/ID valid=0 and ID/EX control all 0. bne with equal operands → out_pc_src=0, out_pc_jump=0x10.
- j 0x0000123 with pc_plus1=0x0400_0008 → out_pc_jump=0x0400_0123, pc_src=1.
- lw r2,4(r1) with in_stall=1 for 2 cycles → IF/ID held, ID/EX control 0 for 2 edges, then mem_read=1, mem_to_reg=1, alu_src=1, out_imm_ext=4.
- Stall asserted while beq taken → out_pc_src=0; release → out_pc_src=1. Opcode 0x3F → bubble.

Source files
------------

// File: rtl/instruction_decode_if.sv
// Decode-stage port bundle: fetch/write-back inputs and the ID/EX outputs.
// master = upstream driver (fetch, write-back, hazard unit), slave = decode stage.
interface instruction_decode_if #(
    parameter int len     = 32,
    parameter int nb_addr = 5
);
    logic [len-1:0]     in_pc_plus1;
    logic [len-1:0]     in_instruction;
    logic               in_stall;
    logic               in_wb_write;
    logic [nb_addr-1:0] in_wb_addr;
    logic [len-1:0]     in_wb_data;

    logic               out_pc_src;
    logic [len-1:0]     out_pc_jump;
    logic [len-1:0]     out_reg_a;
    logic [len-1:0]     out_reg_b;
    logic [len-1:0]     out_imm_ext;
    logic [nb_addr-1:0] out_rs;
    logic [nb_addr-1:0] out_rt;
    logic [nb_addr-1:0] out_rd;
    logic               out_reg_write;
    logic               out_mem_to_reg;
    logic               out_mem_read;
    logic               out_mem_write;
    logic               out_alu_src;
    logic               out_reg_dst;
    logic [1:0]         out_alu_op;

    modport master (
        output in_pc_plus1, in_instruction, in_stall, in_wb_write, in_wb_addr, in_wb_data,
        input  out_pc_src, out_pc_jump, out_reg_a, out_reg_b, out_imm_ext,
               out_rs, out_rt, out_rd, out_reg_write, out_mem_to_reg, out_mem_read,
               out_mem_write, out_alu_src, out_reg_dst, out_alu_op
    );

    modport slave (
        input  in_pc_plus1, in_instruction, in_stall, in_wb_write, in_wb_addr, in_wb_data,
        output out_pc_src, out_pc_jump, out_reg_a, out_reg_b, out_imm_ext,
               out_rs, out_rt, out_rd, out_reg_write, out_mem_to_reg, out_mem_read,
               out_mem_write, out_alu_src, out_reg_dst, out_alu_op
    );
endinterface

// File: rtl/instruction_decode.sv
// MIPS decode stage: IF/ID register, 32-entry register file with write-back
// bypass, control decode, branch/jump resolution and the ID/EX register.
module instruction_decode #(
    parameter int len     = 32,
    parameter int nb_addr = 5
) (
    input logic clk,
    input logic reset,
    instruction_decode_if.slave bus
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    function automatic logic signed [len-1:0] sext_imm(input logic [15:0] imm);
        return {{(len-16){imm[15]}}, imm};
    endfunction

    // IF/ID stage
    logic [len-1:0] instr_p0;
    logic [len-1:0] pc_p0;
    logic           vld_p0;

    // Register file
    logic [len-1:0] regs [2**nb_addr];

    // Decode-side combinational signals
    logic [5:0]              opcode;
    logic [nb_addr-1:0]      rs;
    logic [nb_addr-1:0]      rt;
    logic [nb_addr-1:0]      rd;
    logic signed [len-1:0]   imm_ext;
    logic [len-1:0]          rs_val;
    logic [len-1:0]          rt_val;
    logic                    dec_reg_write;
    logic                    dec_mem_to_reg;
    logic                    dec_mem_read;
    logic                    dec_mem_write;
    logic                    dec_alu_src;
    logic                    dec_reg_dst;
    logic [1:0]              dec_alu_op;
    logic                    take;
    logic signed [len-1:0]   br_target;
    logic [len-1:0]          target;
    logic                    pc_src;

    // ID/EX stage
    logic [len-1:0]     reg_a_p1;
    logic [len-1:0]     reg_b_p1;
    logic [len-1:0]     imm_p1;
    logic [nb_addr-1:0] rs_p1;
    logic [nb_addr-1:0] rt_p1;
    logic [nb_addr-1:0] rd_p1;
    logic               reg_write_p1;
    logic               mem_to_reg_p1;
    logic               mem_read_p1;
    logic               mem_write_p1;
    logic               alu_src_p1;
    logic               reg_dst_p1;
    logic [1:0]         alu_op_p1;

    assign opcode  = instr_p0[31:26];
    assign rs      = instr_p0[25:21];
    assign rt      = instr_p0[20:16];
    assign rd      = instr_p0[15:11];
    assign imm_ext = sext_imm(instr_p0[15:0]);

    // Capture the fetched instruction; a stall holds it, a redirect turns it into a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_p0 <= '0;
            pc_p0    <= '0;
            vld_p0   <= 1'b0;
        end else if (!bus.in_stall) begin
            instr_p0 <= bus.in_instruction;
            pc_p0    <= bus.in_pc_plus1;
            vld_p0   <= !pc_src;
        end
    end

    // Register file write port; r0 is never written so it always reads as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**nb_addr; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.in_wb_write && bus.in_wb_addr != '0) begin
            regs[bus.in_wb_addr] <= bus.in_wb_data;
        end
    end

    // Read ports with same-cycle write-back bypass (never for r0).
    always_comb begin
        rs_val = regs[rs];
        rt_val = regs[rt];
        if (rs == '0) begin
            rs_val = '0;
        end else if (bus.in_wb_write && bus.in_wb_addr == rs) begin
            rs_val = bus.in_wb_data;
        end
        if (rt == '0) begin
            rt_val = '0;
        end else if (bus.in_wb_write && bus.in_wb_addr == rt) begin
            rt_val = bus.in_wb_data;
        end
    end

    // Main control decode; unknown opcodes (and j) decode to all-zero control.
    always_comb begin
        dec_reg_write  = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_alu_src    = 1'b0;
        dec_reg_dst    = 1'b0;
        dec_alu_op     = 2'b00;
        case (opcode)
            OP_RTYPE: begin
                dec_reg_write = 1'b1;
                dec_reg_dst   = 1'b1;
                dec_alu_op    = 2'b10;
            end
            OP_ADDI: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
            end
            OP_LW: begin
                dec_reg_write  = 1'b1;
                dec_alu_src    = 1'b1;
                dec_mem_read   = 1'b1;
                dec_mem_to_reg = 1'b1;
            end
            OP_SW: begin
                dec_alu_src   = 1'b1;
                dec_mem_write = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec_alu_op = 2'b01;
            end
            default: ;
        endcase
    end

    // Branch/jump resolution; a stall suppresses the redirect so the branch is re-evaluated.
    always_comb begin
        take      = ((opcode == OP_BEQ) && (rs_val == rt_val)) ||
                    ((opcode == OP_BNE) && (rs_val != rt_val));
        br_target = $signed(pc_p0) + imm_ext;
        if (opcode == OP_J) begin
            target = {pc_p0[len-1:26], instr_p0[25:0]};
        end else begin
            target = $unsigned(br_target);
        end
        pc_src = vld_p0 && !bus.in_stall && (take || (opcode == OP_J));
    end

    assign bus.out_pc_src  = pc_src;
    assign bus.out_pc_jump = pc_src ? target : pc_p0;

    // ID/EX register: invalid or stalled slots become control bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_a_p1      <= '0;
            reg_b_p1      <= '0;
            imm_p1        <= '0;
            rs_p1         <= '0;
            rt_p1         <= '0;
            rd_p1         <= '0;
            reg_write_p1  <= 1'b0;
            mem_to_reg_p1 <= 1'b0;
            mem_read_p1   <= 1'b0;
            mem_write_p1  <= 1'b0;
            alu_src_p1    <= 1'b0;
            reg_dst_p1    <= 1'b0;
            alu_op_p1     <= 2'b00;
        end else begin
            reg_a_p1 <= rs_val;
            reg_b_p1 <= rt_val;
            imm_p1   <= $unsigned(imm_ext);
            rs_p1    <= rs;
            rt_p1    <= rt;
            rd_p1    <= rd;
            if (!vld_p0 || bus.in_stall) begin
                reg_write_p1  <= 1'b0;
                mem_to_reg_p1 <= 1'b0;
                mem_read_p1   <= 1'b0;
                mem_write_p1  <= 1'b0;
                alu_src_p1    <= 1'b0;
                reg_dst_p1    <= 1'b0;
                alu_op_p1     <= 2'b00;
            end else begin
                reg_write_p1  <= dec_reg_write;
                mem_to_reg_p1 <= dec_mem_to_reg;
                mem_read_p1   <= dec_mem_read;
                mem_write_p1  <= dec_mem_write;
                alu_src_p1    <= dec_alu_src;
                reg_dst_p1    <= dec_reg_dst;
                alu_op_p1     <= dec_alu_op;
            end
        end
    end

    assign bus.out_reg_a      = reg_a_p1;
    assign bus.out_reg_b      = reg_b_p1;
    assign bus.out_imm_ext    = imm_p1;
    assign bus.out_rs         = rs_p1;
    assign bus.out_rt         = rt_p1;
    assign bus.out_rd         = rd_p1;
    assign bus.out_reg_write  = reg_write_p1;
    assign bus.out_mem_to_reg = mem_to_reg_p1;
    assign bus.out_mem_read   = mem_read_p1;
    assign bus.out_mem_write  = mem_write_p1;
    assign bus.out_alu_src    = alu_src_p1;
    assign bus.out_reg_dst    = reg_dst_p1;
    assign bus.out_alu_op     = alu_op_p1;
endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: a table of per-cycle vectors plus
// hand-written reset, stall-release and mid-run reset sequences.
module tb_instruction_decode;
    logic clk = 1'b0;
    logic reset;

    instruction_decode_if #(.len(32), .nb_addr(5)) bus ();

    instruction_decode #(.len(32), .nb_addr(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        stall;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        src;
        logic [31:0] jump;
        logic        chkj;
        logic [5:0]  ctrl;   // {reg_write, mem_to_reg, mem_read, mem_write, alu_src, reg_dst}
        logic [1:0]  alu;
        logic        chkd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } vec_t;

    vec_t vecs [17];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s [step %0d]: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    function automatic logic [5:0] ctrl_now();
        return {bus.out_reg_write, bus.out_mem_to_reg, bus.out_mem_read,
                bus.out_mem_write, bus.out_alu_src, bus.out_reg_dst};
    endfunction

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic stall,
                         input logic we, input logic [4:0] waddr, input logic [31:0] wdata);
        bus.in_instruction = instr;
        bus.in_pc_plus1    = pc;
        bus.in_stall       = stall;
        bus.in_wb_write    = we;
        bus.in_wb_addr     = waddr;
        bus.in_wb_data     = wdata;
    endtask

    initial begin
        // Table: inputs held for one edge, outputs checked 1 time unit after it.
        vecs[0]  = '{32'h2064FFFF, 32'h01, 0, 0, 5'd0, 32'h0,  0, 32'h01, 1, 6'b000000, 2'b00, 0, 32'h0,  32'h0,  32'h0,        5'd0, 5'd0, 5'd0};
        vecs[1]  = '{32'hAC030008, 32'h02, 0, 0, 5'd0, 32'h0,  0, 32'h02, 1, 6'b100010, 2'b00, 1, 32'h0,  32'h0,  32'hFFFFFFFF, 5'd3, 5'd4, 5'd31};
        vecs[2]  = '{32'h00A00820, 32'h03, 0, 0, 5'd0, 32'h0,  0, 32'h03, 1, 6'b000110, 2'b00, 1, 32'h0,  32'h0,  32'h8,        5'd0, 5'd3, 5'd0};
        vecs[3]  = '{32'h00630820, 32'h04, 0, 0, 5'd0, 32'h0,  0, 32'h04, 1, 6'b100001, 2'b10, 1, 32'h0,  32'h0,  32'h820,      5'd5, 5'd0, 5'd1};
        vecs[4]  = '{32'h00000000, 32'h05, 0, 1, 5'd3, 32'hAA, 0, 32'h05, 1, 6'b100001, 2'b10, 1, 32'hAA, 32'hAA, 32'h820,      5'd3, 5'd3, 5'd1};
        vecs[5]  = '{32'h00030820, 32'h06, 0, 1, 5'd0, 32'h55, 0, 32'h06, 1, 6'b100001, 2'b10, 1, 32'h0,  32'h0,  32'h0,        5'd0, 5'd0, 5'd0};
        vecs[6]  = '{32'h1063FFFE, 32'h10, 0, 0, 5'd0, 32'h0,  1, 32'h0E, 1, 6'b100001, 2'b10, 1, 32'h0,  32'hAA, 32'h820,      5'd0, 5'd3, 5'd1};
        vecs[7]  = '{32'h00A00820, 32'h11, 0, 0, 5'd0, 32'h0,  0, 32'h0,  0, 6'b000000, 2'b01, 1, 32'hAA, 32'hAA, 32'hFFFFFFFE, 5'd3, 5'd3, 5'd31};
        vecs[8]  = '{32'h1463FFFE, 32'h10, 0, 0, 5'd0, 32'h0,  0, 32'h10, 1, 6'b000000, 2'b00, 0, 32'h0,  32'h0,  32'h0,        5'd0, 5'd0, 5'd0};
        vecs[9]  = '{32'h08000123, 32'h04000008, 0, 0, 5'd0, 32'h0, 1, 32'h04000123, 1, 6'b000000, 2'b01, 1, 32'hAA, 32'hAA, 32'hFFFFFFFE, 5'd3, 5'd3, 5'd31};
        vecs[10] = '{32'h00000000, 32'h05, 0, 0, 5'd0, 32'h0,  0, 32'h0,  0, 6'b000000, 2'b00, 1, 32'h0,  32'h0,  32'h123,      5'd0, 5'd0, 5'd0};
        vecs[11] = '{32'h8C220004, 32'h20, 0, 0, 5'd0, 32'h0,  0, 32'h20, 1, 6'b000000, 2'b00, 0, 32'h0,  32'h0,  32'h0,        5'd0, 5'd0, 5'd0};
        vecs[12] = '{32'hFC000000, 32'h21, 1, 0, 5'd0, 32'h0,  0, 32'h20, 1, 6'b000000, 2'b00, 0, 32'h0,  32'h0,  32'h0,        5'd0, 5'd0, 5'd0};
        vecs[13] = '{32'hFC000000, 32'h22, 1, 0, 5'd0, 32'h0,  0, 32'h20, 1, 6'b000000, 2'b00, 0, 32'h0,  32'h0,  32'h0,        5'd0, 5'd0, 5'd0};
        vecs[14] = '{32'hFC000000, 32'h30, 0, 0, 5'd0, 32'h0,  0, 32'h30, 1, 6'b111010, 2'b00, 1, 32'h0,  32'h0,  32'h4,        5'd1, 5'd2, 5'd0};
        vecs[15] = '{32'h1063FFFE, 32'h40, 0, 0, 5'd0, 32'h0,  1, 32'h3E, 1, 6'b000000, 2'b00, 1, 32'h0,  32'h0,  32'h0,        5'd0, 5'd0, 5'd0};
        vecs[16] = '{32'h00000000, 32'h50, 1, 0, 5'd0, 32'h0,  0, 32'h40, 1, 6'b000000, 2'b00, 0, 32'h0,  32'h0,  32'h0,        5'd0, 5'd0, 5'd0};

        // Reset held for three cycles with garbage on every input.
        reset = 1'b1;
        drive(32'hDEADBEEF, 32'h12345678, 1'b1, 1'b1, 5'd7, 32'hCAFEF00D);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pc_src", -1, {31'b0, bus.out_pc_src}, 32'h0);
        chk("rst_pc_jump", -1, bus.out_pc_jump, 32'h0);
        chk("rst_ctrl", -1, {26'b0, ctrl_now()}, 32'h0);
        chk("rst_alu_op", -1, {30'b0, bus.out_alu_op}, 32'h0);
        chk("rst_reg_a", -1, bus.out_reg_a, 32'h0);
        chk("rst_reg_b", -1, bus.out_reg_b, 32'h0);
        chk("rst_imm", -1, bus.out_imm_ext, 32'h0);
        chk("rst_fields", -1, {17'b0, bus.out_rs, bus.out_rt, bus.out_rd}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].instr, vecs[i].pc, vecs[i].stall, vecs[i].we, vecs[i].waddr, vecs[i].wdata);
            @(posedge clk);
            #1;
            chk("pc_src", i, {31'b0, bus.out_pc_src}, {31'b0, vecs[i].src});
            if (vecs[i].chkj) chk("pc_jump", i, bus.out_pc_jump, vecs[i].jump);
            chk("ctrl", i, {26'b0, ctrl_now()}, {26'b0, vecs[i].ctrl});
            chk("alu_op", i, {30'b0, bus.out_alu_op}, {30'b0, vecs[i].alu});
            if (vecs[i].chkd) begin
                chk("reg_a", i, bus.out_reg_a, vecs[i].a);
                chk("reg_b", i, bus.out_reg_b, vecs[i].b);
                chk("imm_ext", i, bus.out_imm_ext, vecs[i].imm);
                chk("rs_rt_rd", i, {17'b0, bus.out_rs, bus.out_rt, bus.out_rd},
                    {17'b0, vecs[i].rs, vecs[i].rt, vecs[i].rd});
            end
            @(negedge clk);
        end

        // Stall released with the taken beq still held in IF/ID: redirect appears now.
        drive(32'h2064FFFF, 32'h60, 1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        chk("release_pc_src", 17, {31'b0, bus.out_pc_src}, 32'h1);
        chk("release_pc_jump", 17, bus.out_pc_jump, 32'h3E);
        @(posedge clk);
        #1;
        chk("release_alu_op", 18, {30'b0, bus.out_alu_op}, 32'h1);
        chk("release_ctrl", 18, {26'b0, ctrl_now()}, 32'h0);
        chk("flushed_pc_src", 18, {31'b0, bus.out_pc_src}, 32'h0);

        // Reset mid-run wins over stall and write-back; register file is cleared.
        @(negedge clk);
        reset = 1'b1;
        drive(32'h00630820, 32'h70, 1'b1, 1'b1, 5'd3, 32'h77);
        @(posedge clk);
        #1;
        chk("midrst_ctrl", 19, {26'b0, ctrl_now()}, 32'h0);
        chk("midrst_reg_a", 19, bus.out_reg_a, 32'h0);
        chk("midrst_pc_jump", 19, bus.out_pc_jump, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(32'h00630820, 32'h01, 1'b0, 1'b0, 5'd0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        drive(32'h00000000, 32'h02, 1'b0, 1'b0, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        chk("cleared_r3_a", 20, bus.out_reg_a, 32'h0);
        chk("cleared_r3_b", 20, bus.out_reg_b, 32'h0);
        chk("after_rst_ctrl", 20, {26'b0, ctrl_now()}, 32'h21);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
